// File: rtl/e15_pkg.sv
// ----------------------------------------------------------------------------
// e15_pkg
// Shared definitions for the parametrised E15 multicycle core:
//   - 4-bit opcode encodings
//   - FSM state encodings (legacy-compatible localparam constants)
//   - opcode classification helpers used by decode/exec/store
// Optional feature macro: E15_CARRY_FLAG_EN (adds jc/jnc opcodes).
// ----------------------------------------------------------------------------
package e15_pkg;

    // Opcodes
    localparam logic [3:0] OP_JMP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_JZ   = 4'b0010;
    localparam logic [3:0] OP_JNZ  = 4'b0011;
    localparam logic [3:0] OP_JC   = 4'b0100;
    localparam logic [3:0] OP_JNC  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b1000;
    localparam logic [3:0] OP_MOVI = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_ADDI = 4'b1011;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101;
    localparam logic [3:0] OP_CMP  = 4'b1110;
    localparam logic [3:0] OP_CMPI = 4'b1111;

    // FSM states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_STORE  = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    // Immediate-operand forms of the register/ALU instructions.
    function automatic logic op_uses_imm(input logic [3:0] op);
        return (op == OP_MOVI) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
    endfunction

    // Instructions whose ALU runs in subtract mode (cmp shares the subtractor).
    function automatic logic op_is_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SUBI) || (op == OP_CMP) || (op == OP_CMPI);
    endfunction

    // Instructions that update the flags at the end of EXEC.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || op_is_sub(op);
    endfunction

    // Instructions whose result is written back to reg[dst] in STORE.
    function automatic logic op_writes_reg(input logic [3:0] op);
        return (op == OP_MOV) || (op == OP_MOVI) || (op == OP_ADD) || (op == OP_ADDI)
            || (op == OP_SUB) || (op == OP_SUBI);
    endfunction

    function automatic logic op_is_mov(input logic [3:0] op);
        return (op == OP_MOV) || (op == OP_MOVI);
    endfunction

endpackage

// File: rtl/e15_alu.sv
// ----------------------------------------------------------------------------
// e15_alu
// Add/subtract unit for the E15 core, shared by add/sub and cmp.
// Ports:
//   a, b    in  DATA_W  operands (a = reg[dst], b = register or immediate)
//   sub     in  1       0: a+b, 1: a-b
//   result  out DATA_W  result mod 2^DATA_W
//   zero    out 1       result == 0
//   carry   out 1       carry-out for add, borrow (a<b unsigned) for sub
// ----------------------------------------------------------------------------
module e15_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    // One extra bit: the MSB is carry-out on add and borrow on subtract.
    logic [DATA_W:0] wide;

    always_comb begin
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];
    assign zero   = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/e15_param_core.sv
// ----------------------------------------------------------------------------
// e15_param_core
// Parametrised four-phase (FETCH/DECODE/EXEC/STORE) multicycle processor
// with a register file, a runtime-loadable program memory, run/halt control
// and a debug register read port.
// Optional feature macro: E15_CARRY_FLAG_EN (carry flag C, c_flag_o, jc/jnc).
// Ports:
//   clk         in   1        clock, all state on posedge
//   rst         in   1        asynchronous active-high reset
//   run         in   1        start from IDLE, restart (pc=0) from HALT
//   prog_we     in   1        program write strobe (IDLE/HALT only)
//   prog_addr   in   PC_W     program write address
//   prog_wdata  in   INSTR_W  {opcode[3:0], src, dst, imm}
//   dbg_sel     in   REG_W    debug register select
//   dbg_data    out  DATA_W   register[dbg_sel], combinational
//   pc_o        out  PC_W     program counter
//   z_flag_o    out  1        zero flag
//   halted      out  1        high in HALT
//   busy        out  1        high in FETCH..STORE
//   c_flag_o    out  1        carry/borrow flag (E15_CARRY_FLAG_EN only)
// ----------------------------------------------------------------------------
module e15_param_core
    import e15_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NUM_REGS   = 4,
    parameter  int PROG_DEPTH = 16,
    localparam int REG_W      = $clog2(NUM_REGS),
    localparam int PC_W       = $clog2(PROG_DEPTH),
    localparam int INSTR_W    = 4 + 2 * REG_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic [REG_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [PC_W-1:0]    pc_o,
    output logic               z_flag_o,
    output logic               halted,
    output logic               busy
`ifdef E15_CARRY_FLAG_EN
    ,
    output logic               c_flag_o
`endif
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [3:0]          op_q, op_d;
    logic [REG_W-1:0]    src_q, src_d;
    logic [REG_W-1:0]    dst_q, dst_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                z_q, z_d;
`ifdef E15_CARRY_FLAG_EN
    logic                c_q, c_d;
`endif
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [INSTR_W-1:0]  mem_q  [PROG_DEPTH];
    logic                mem_we;

    logic [INSTR_W-1:0]  instr;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_zero;
    logic                alu_carry;
    logic                take_jump;
    logic [PC_W-1:0]     pc_seq;
    logic [PC_W-1:0]     pc_jump;

    assign instr = mem_q[pc_q];

    e15_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (regs_q[dst_q]),
        .b      (opnd_q),
        .sub    (op_is_sub(op_q)),
        .result (alu_res),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

`ifndef E15_CARRY_FLAG_EN
    // Carry is only consumed when the carry-flag feature is built in.
    logic unused_alu_carry;
    assign unused_alu_carry = alu_carry;
`endif

    // Relative jump target and sequential successor, both mod PROG_DEPTH.
    assign pc_seq  = pc_q + PC_W'(1);
    assign pc_jump = pc_q + imm_q[PC_W-1:0];

    // Jump conditions read the flags as left by the last flag-setting op.
    always_comb begin
        take_jump = 1'b0;
        case (op_q)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = z_q;
            OP_JNZ:  take_jump = ~z_q;
`ifdef E15_CARRY_FLAG_EN
            OP_JC:   take_jump = c_q;
            OP_JNC:  take_jump = ~c_q;
`endif
            default: take_jump = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default at the top of the block so that no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        z_d     = z_q;
`ifdef E15_CARRY_FLAG_EN
        c_d     = c_q;
`endif
        regs_d  = regs_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_we = prog_we;
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                op_d    = instr[INSTR_W-1 -: 4];
                src_d   = instr[DATA_W+REG_W +: REG_W];
                dst_d   = instr[DATA_W +: REG_W];
                imm_d   = instr[DATA_W-1:0];
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opnd_d  = op_uses_imm(op_q) ? imm_q : regs_q[src_q];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d = op_is_mov(op_q) ? opnd_q : alu_res;
                if (op_sets_flags(op_q)) begin
                    z_d = alu_zero;
`ifdef E15_CARRY_FLAG_EN
                    c_d = alu_carry;
`endif
                end
                state_d = ST_STORE;
            end
            ST_STORE: begin
                if (op_writes_reg(op_q)) regs_d[dst_q] = res_q;
                pc_d    = take_jump ? pc_jump : pc_seq;
                state_d = (op_q == OP_HALT) ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                mem_we = prog_we;
                if (run) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
`ifdef E15_CARRY_FLAG_EN
            c_q     <= 1'b0;
`endif
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            z_q     <= z_d;
`ifdef E15_CARRY_FLAG_EN
            c_q     <= c_d;
`endif
            regs_q  <= regs_d;
        end
    end

    // NOTE: program memory has no reset; it keeps its contents across rst so
    // a loaded program survives, and it maps onto plain RAM without a clear.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[prog_addr] <= prog_wdata;
    end

    assign dbg_data = regs_q[dbg_sel];
    assign pc_o     = pc_q;
    assign z_flag_o = z_q;
    assign halted   = (state_q == ST_HALT);
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE)
                   || (state_q == ST_EXEC)  || (state_q == ST_STORE);
`ifdef E15_CARRY_FLAG_EN
    assign c_flag_o = c_q;
`endif

endmodule

// File: tb/tb_e15_param_core.sv
// ----------------------------------------------------------------------------
// tb_e15_param_core
// Self-checking bench for e15_param_core (default parameters). Directed
// programs plus random programs compared against an instruction-level
// reference interpreter. Honours E15_CARRY_FLAG_EN when defined.
// ----------------------------------------------------------------------------
module tb_e15_param_core;

    localparam int DATA_W  = 8;
    localparam int NREG    = 4;
    localparam int DEPTH   = 16;
    localparam int INSTR_W = 16;

    logic               clk;
    logic               rst;
    logic               run;
    logic               prog_we;
    logic [3:0]         prog_addr;
    logic [INSTR_W-1:0] prog_wdata;
    logic [1:0]         dbg_sel;
    logic [DATA_W-1:0]  dbg_data;
    logic [3:0]         pc_o;
    logic               z_flag_o;
    logic               halted;
    logic               busy;
`ifdef E15_CARRY_FLAG_EN
    logic               c_flag_o;
`endif

    e15_param_core #(.DATA_W(DATA_W), .NUM_REGS(NREG), .PROG_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .pc_o       (pc_o),
        .z_flag_o   (z_flag_o),
        .halted     (halted),
        .busy       (busy)
`ifdef E15_CARRY_FLAG_EN
        ,
        .c_flag_o   (c_flag_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Program image and ISA-level reference state.
    logic [INSTR_W-1:0] prog [DEPTH];
    int m_reg [NREG];
    int m_pc;
    bit m_z, m_c, m_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INSTR_W-1:0] enc(input int op, input int src, input int dst, input int imm);
        logic [3:0] o;
        logic [1:0] s;
        logic [1:0] d;
        logic [7:0] i;
        o = 4'(op);
        s = 2'(src);
        d = 2'(dst);
        i = 8'(imm);
        return {o, s, d, i};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        m_pc = 0; m_z = 0; m_c = 0; m_halted = 0;
        for (int i = 0; i < NREG; i++) m_reg[i] = 0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = enc(1, 0, 0, 0);
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 4'(i);
            prog_wdata = prog[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    // After this returns the core is in FETCH of its first instruction.
    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic read_reg(input int idx, output logic [DATA_W-1:0] val);
        dbg_sel = 2'(idx);
        #1;
        val = dbg_data;
    endtask

    // Reference interpreter: one whole instruction per call.
    task automatic model_step();
        logic [INSTR_W-1:0] w;
        int op, src, dst, imm, opnd, nxt, tmp;
        w    = prog[m_pc];
        op   = int'(w[15:12]);
        src  = int'(w[11:10]);
        dst  = int'(w[9:8]);
        imm  = int'(w[7:0]);
        opnd = (op >= 8 && (op % 2) == 1) ? imm : m_reg[src];
        nxt  = (m_pc + 1) % DEPTH;
        case (op)
            0: nxt = (m_pc + imm) % DEPTH;
            1: m_halted = 1;
            2: if (m_z)  nxt = (m_pc + imm) % DEPTH;
            3: if (!m_z) nxt = (m_pc + imm) % DEPTH;
`ifdef E15_CARRY_FLAG_EN
            4: if (m_c)  nxt = (m_pc + imm) % DEPTH;
            5: if (!m_c) nxt = (m_pc + imm) % DEPTH;
`endif
            8, 9: m_reg[dst] = opnd;
            10, 11: begin
                tmp        = m_reg[dst] + opnd;
                m_c        = (tmp > 255);
                m_reg[dst] = tmp % 256;
                m_z        = (m_reg[dst] == 0);
            end
            12, 13: begin
                m_c        = (m_reg[dst] < opnd);
                m_reg[dst] = (m_reg[dst] - opnd + 256) % 256;
                m_z        = (m_reg[dst] == 0);
            end
            14, 15: begin
                m_c = (m_reg[dst] < opnd);
                tmp = (m_reg[dst] - opnd + 256) % 256;
                m_z = (tmp == 0);
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic model_run(input int limit, output int n);
        n = 0;
        while (!m_halted && n < limit) begin
            model_step();
            n++;
        end
    endtask

    task automatic check_vs_model(input string tag);
        logic [DATA_W-1:0] v;
        for (int i = 0; i < NREG; i++) begin
            read_reg(i, v);
            check($sformatf("%s r%0d", tag, i), 32'(v), 32'(m_reg[i]));
        end
        check({tag, " z"}, 32'(z_flag_o), 32'(m_z));
`ifdef E15_CARRY_FLAG_EN
        check({tag, " c"}, 32'(c_flag_o), 32'(m_c));
`endif
        check({tag, " halted"}, 32'(halted), 32'(m_halted));
        if (!m_halted) check({tag, " pc"}, 32'(pc_o), 32'(m_pc));
    endtask

    // Global guard so the bench can never hang.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] v;
        int n;
        rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_wdata = '0; dbg_sel = '0;

        // Reset state.
        do_reset();
        check("rst pc", 32'(pc_o), 0);
        check("rst z", 32'(z_flag_o), 0);
        check("rst busy", 32'(busy), 0);
        check("rst halted", 32'(halted), 0);
        read_reg(0, v);
        check("rst r0", 32'(v), 0);

        // Reset in the middle of addi r0,5 (after movi r1,9 completed).
        clear_prog();
        prog[0] = enc(9, 0, 1, 9);
        prog[1] = enc(11, 0, 0, 5);
        load_prog();
        start_run();
        check("t1 busy", 32'(busy), 1);
        repeat (4) tick();
        read_reg(1, v);
        check("t1 r1 before", 32'(v), 9);
        check("t1 pc before", 32'(pc_o), 1);
        tick();
        tick();
        #1 rst = 1'b1;
        read_reg(1, v);
        check("t1 r1 in rst", 32'(v), 0);
        read_reg(0, v);
        check("t1 r0 in rst", 32'(v), 0);
        check("t1 pc in rst", 32'(pc_o), 0);
        check("t1 busy in rst", 32'(busy), 0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("t1 idle busy", 32'(busy), 0);
        read_reg(0, v);
        check("t1 r0 after", 32'(v), 0);

        // movi r1,200; addi r1,100; halt -> wraps to 44, HALT after 12 cycles.
        do_reset();
        clear_prog();
        prog[0] = enc(9, 0, 1, 200);
        prog[1] = enc(11, 0, 1, 100);
        load_prog();
        start_run();
        repeat (11) tick();
        check("t2 halted early", 32'(halted), 0);
        tick();
        check("t2 halted", 32'(halted), 1);
        check("t2 busy", 32'(busy), 0);
        read_reg(1, v);
        check("t2 r1", 32'(v), 44);
        check("t2 z", 32'(z_flag_o), 0);

        // Countdown loop: 8 instructions, 32 cycles.
        do_reset();
        clear_prog();
        prog[0] = enc(9, 0, 2, 3);
        prog[1] = enc(13, 0, 2, 1);
        prog[2] = enc(3, 0, 0, 8'hFF);
        load_prog();
        start_run();
        repeat (31) tick();
        check("t3 halted early", 32'(halted), 0);
        tick();
        check("t3 halted", 32'(halted), 1);
        read_reg(2, v);
        check("t3 r2", 32'(v), 0);
        check("t3 z", 32'(z_flag_o), 1);

        // cmpi r0,0 then jz +2 skips movi r0,7.
        do_reset();
        clear_prog();
        prog[0] = enc(15, 0, 0, 0);
        prog[1] = enc(2, 0, 0, 2);
        prog[2] = enc(9, 0, 0, 7);
        load_prog();
        start_run();
        repeat (12) tick();
        check("t4 halted", 32'(halted), 1);
        read_reg(0, v);
        check("t4 r0", 32'(v), 0);
        check("t4 z", 32'(z_flag_o), 1);

        // pc wrap 15+3 -> 2, and a write attempted while busy is dropped.
        do_reset();
        clear_prog();
        prog[0]  = enc(0, 0, 0, 15);
        prog[15] = enc(0, 0, 0, 3);
        prog[3]  = enc(9, 0, 3, 1);
        load_prog();
        start_run();
        prog_we    = 1'b1;
        prog_addr  = 4'd2;
        prog_wdata = enc(9, 0, 3, 99);
        tick();
        prog_we = 1'b0;
        check("t5 pc mid", 32'(pc_o), 0);
        repeat (7) tick();
        check("t5 pc wrap", 32'(pc_o), 2);
        check("t5 busy", 32'(busy), 1);
        repeat (4) tick();
        check("t5 halted", 32'(halted), 1);
        read_reg(3, v);
        check("t5 r3", 32'(v), 0);

        // Carry: movi r0,255; addi r0,1; jc +2; movi r1,5; halt.
        do_reset();
        clear_prog();
        prog[0] = enc(9, 0, 0, 255);
        prog[1] = enc(11, 0, 0, 1);
        prog[2] = enc(4, 0, 0, 2);
        prog[3] = enc(9, 0, 1, 5);
        load_prog();
        start_run();
`ifdef E15_CARRY_FLAG_EN
        repeat (16) tick();
        check("t6 c", 32'(c_flag_o), 1);
        read_reg(1, v);
        check("t6 r1", 32'(v), 0);
`else
        repeat (20) tick();
        read_reg(1, v);
        check("t6 r1", 32'(v), 5);
`endif
        check("t6 halted", 32'(halted), 1);
        read_reg(0, v);
        check("t6 r0", 32'(v), 0);
        check("t6 z", 32'(z_flag_o), 1);

        // Random programs against the reference interpreter, with restart.
        for (int t = 0; t < 24; t++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++)
                prog[i] = enc($urandom_range(0, 15), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 255));
            load_prog();
            start_run();
            model_run(40, n);
            repeat (4 * n) tick();
            check_vs_model($sformatf("rnd%0d", t));
            if (m_halted) begin
                start_run();
                m_pc = 0;
                m_halted = 0;
                model_run(20, n);
                repeat (4 * n) tick();
                check_vs_model($sformatf("rnd%0d restart", t));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
